// File: rtl/sounder_rx_sched.sv
// Schedule gate and packetiser for the channel-sounder RX stream: guard/window/repeat gating, SPP packets, timestamps, EOB.
// Optional statistics outputs (stat_snaps, stat_stall) are built when SOUNDER_RX_SCHED_STATS_EN is defined.
module sounder_rx_sched #(
  parameter int WIDTH = 32,
  parameter int NIPC  = 2,
  parameter int CNT_W = 32,
  parameter int ANT_W = 8,
  parameter int SPP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [NIPC*WIDTH-1:0] i_axis_tdata,
  input  logic                  i_axis_tlast,
  input  logic                  i_axis_tvalid,
  output logic                  i_axis_tready,
  input  logic [63:0]           i_axis_ttimestamp,
  input  logic                  i_axis_thas_time,
  output logic [NIPC*WIDTH-1:0] o_axis_tdata,
  output logic [NIPC-1:0]       o_axis_tkeep,
  output logic                  o_axis_tlast,
  output logic                  o_axis_tvalid,
  input  logic                  o_axis_tready,
  output logic [63:0]           o_axis_ttimestamp,
  output logic                  o_axis_thas_time,
  output logic                  o_axis_teob,
  output logic                  o_axis_teov,
  input  logic [CNT_W-1:0]      p,
  input  logic [CNT_W-1:0]      r,
  input  logic [CNT_W-1:0]      ml,
  input  logic [ANT_W-1:0]      nant,
  input  logic [15:0]           nsnap,
  input  logic [SPP_W-1:0]      spp,
  output logic                  busy
`ifdef SOUNDER_RX_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_snaps,
  output logic [31:0]           stat_stall
`endif
);
  typedef enum logic [1:0] {IDLE, SKIP_P, ACTIVE, SKIP_R} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ANT_W-1:0] ANT_ONE = ANT_W'(1);
  localparam logic [SPP_W-1:0] SPP_ONE = SPP_W'(1);

  state_t                state_q, state_d, cur;
  logic                  arm_q, arm_d, arm_rise, start, fire;
  logic [CNT_W-1:0]      p_q, p_d, r_q, r_d, ml_q, ml_d, cnt_q, cnt_d;
  logic [CNT_W-1:0]      cp, cr, cml, cnt;
  logic [ANT_W-1:0]      nant_q, nant_d, ant_q, ant_d, cnant, ant;
  logic [15:0]           nsnap_q, nsnap_d, snap_q, snap_d, cnsnap, snap;
  logic [SPP_W-1:0]      spp_q, spp_d, pkt_q, pkt_d, cspp, pkt;
  logic                  in_first_q, in_first_d, in_has_q, in_has_d;
  logic [63:0]           base_q, base_d, off_q, off_d;
  logic [63:0]           beat_base, beat_off, beat_ts;
  logic                  beat_has;
  logic [63:0]           pkt_ts_q, pkt_ts_d;
  logic                  pkt_has_q, pkt_has_d;
  logic [NIPC*WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_valid_q, o_valid_d, o_last_q, o_last_d, o_eob_q, o_eob_d;
  logic [63:0]           o_ts_q, o_ts_d;
  logic                  o_has_q, o_has_d;
  logic                  win_end, pkt_end, snap_done;

  // On the starting cycle the freshly presented config and reset counters apply to the
  // same beat, so that beat already counts as the first guard (or window) beat.
  always_comb begin
    arm_rise = arm & ~arm_q;
    start    = (state_q == IDLE) & arm_rise;
    if (start) begin
      cp     = p;
      cr     = r;
      cml    = (ml == '0) ? CNT_ONE : ml;
      cnant  = (nant == '0) ? ANT_ONE : nant;
      cnsnap = nsnap;
      cspp   = (spp == '0) ? SPP_ONE : spp;
      cur    = (p == '0) ? ACTIVE : SKIP_P;
      cnt    = CNT_ONE;
      ant    = ANT_ONE;
      snap   = 16'd1;
      pkt    = SPP_ONE;
    end else begin
      cp     = p_q;
      cr     = r_q;
      cml    = ml_q;
      cnant  = nant_q;
      cnsnap = nsnap_q;
      cspp   = spp_q;
      cur    = state_q;
      cnt    = cnt_q;
      ant    = ant_q;
      snap   = snap_q;
      pkt    = pkt_q;
    end
    i_axis_tready = (cur == ACTIVE) ? (~o_valid_q | o_axis_tready) : 1'b1;
    fire          = i_axis_tvalid & i_axis_tready;
    beat_base     = in_first_q ? i_axis_ttimestamp : base_q;
    beat_off      = in_first_q ? 64'd0 : off_q;
    beat_has      = in_first_q ? i_axis_thas_time : in_has_q;
    beat_ts       = beat_base + 64'(NIPC) * beat_off;
  end

  always_comb begin
    arm_d      = arm;
    state_d    = cur;
    p_d        = cp;
    r_d        = cr;
    ml_d       = cml;
    nant_d     = cnant;
    nsnap_d    = cnsnap;
    spp_d      = cspp;
    cnt_d      = cnt;
    ant_d      = ant;
    snap_d     = snap;
    pkt_d      = pkt;
    in_first_d = in_first_q;
    in_has_d   = in_has_q;
    base_d     = base_q;
    off_d      = off_q;
    pkt_ts_d   = pkt_ts_q;
    pkt_has_d  = pkt_has_q;
    o_data_d   = o_data_q;
    o_valid_d  = o_valid_q;
    o_last_d   = o_last_q;
    o_eob_d    = o_eob_q;
    o_ts_d     = o_ts_q;
    o_has_d    = o_has_q;
    win_end    = 1'b0;
    pkt_end    = 1'b0;
    snap_done  = 1'b0;

    // Timestamp tracking runs on every accepted beat, forwarded or not.
    if (fire) begin
      in_first_d = i_axis_tlast;
      base_d     = beat_base;
      off_d      = beat_off + 64'd1;
      in_has_d   = beat_has;
    end
    if (o_valid_q & o_axis_tready) o_valid_d = 1'b0;

    if (((cur == SKIP_P) || (cur == SKIP_R)) && !arm) begin
      state_d = IDLE;
    end else if (fire) begin
      case (cur)
        SKIP_P: begin
          if (cnt == cp) begin
            state_d = ACTIVE;
            cnt_d   = CNT_ONE;
          end else cnt_d = cnt + CNT_ONE;
        end
        SKIP_R: begin
          if (cnt == cr) begin
            state_d = ACTIVE;
            cnt_d   = CNT_ONE;
            ant_d   = ANT_ONE;
          end else cnt_d = cnt + CNT_ONE;
        end
        ACTIVE: begin
          win_end   = (cnt == cml);
          pkt_end   = win_end | (pkt == cspp);
          o_valid_d = 1'b1;
          o_data_d  = i_axis_tdata;
          o_last_d  = pkt_end;
          o_eob_d   = win_end & !(ant < cnant);
          o_ts_d    = (pkt == SPP_ONE) ? beat_ts : pkt_ts_q;
          o_has_d   = (pkt == SPP_ONE) ? beat_has : pkt_has_q;
          if (pkt == SPP_ONE) begin
            pkt_ts_d  = beat_ts;
            pkt_has_d = beat_has;
          end
          pkt_d = pkt_end ? SPP_ONE : pkt + SPP_ONE;
          cnt_d = win_end ? CNT_ONE : cnt + CNT_ONE;
          if (win_end) begin
            if (ant < cnant) begin
              ant_d   = ant + ANT_ONE;
              state_d = !arm ? IDLE : ((cp == '0) ? ACTIVE : SKIP_P);
            end else begin
              snap_done = 1'b1;
              ant_d     = ANT_ONE;
              if (!arm || ((cnsnap != 16'd0) && (snap == cnsnap))) begin
                state_d = IDLE;
              end else begin
                snap_d  = snap + 16'd1;
                state_d = (cr == '0) ? ACTIVE : SKIP_R;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SOUNDER_RX_SCHED_STATS_EN
  logic [31:0] stat_snaps_q, stat_snaps_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_snaps_d = stat_snaps_q;
    stat_stall_d = stat_stall_q;
    if (start) begin
      stat_snaps_d = '0;
      stat_stall_d = '0;
    end else begin
      if (snap_done && (stat_snaps_q != '1)) stat_snaps_d = stat_snaps_q + 32'd1;
      if ((state_q == ACTIVE) && o_valid_q && !o_axis_tready && (stat_stall_q != '1))
        stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_snaps_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_snaps_q <= stat_snaps_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_snaps = stat_snaps_q;
  assign stat_stall = stat_stall_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      p_q        <= '0;
      r_q        <= '0;
      ml_q       <= CNT_ONE;
      nant_q     <= ANT_ONE;
      nsnap_q    <= '0;
      spp_q      <= SPP_ONE;
      cnt_q      <= CNT_ONE;
      ant_q      <= ANT_ONE;
      snap_q     <= 16'd1;
      pkt_q      <= SPP_ONE;
      in_first_q <= 1'b1;
      in_has_q   <= 1'b0;
      base_q     <= '0;
      off_q      <= '0;
      pkt_ts_q   <= '0;
      pkt_has_q  <= 1'b0;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_eob_q    <= 1'b0;
      o_ts_q     <= '0;
      o_has_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      p_q        <= p_d;
      r_q        <= r_d;
      ml_q       <= ml_d;
      nant_q     <= nant_d;
      nsnap_q    <= nsnap_d;
      spp_q      <= spp_d;
      cnt_q      <= cnt_d;
      ant_q      <= ant_d;
      snap_q     <= snap_d;
      pkt_q      <= pkt_d;
      in_first_q <= in_first_d;
      in_has_q   <= in_has_d;
      base_q     <= base_d;
      off_q      <= off_d;
      pkt_ts_q   <= pkt_ts_d;
      pkt_has_q  <= pkt_has_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_last_q   <= o_last_d;
      o_eob_q    <= o_eob_d;
      o_ts_q     <= o_ts_d;
      o_has_q    <= o_has_d;
    end
  end

  assign o_axis_tdata      = o_data_q;
  assign o_axis_tkeep      = {NIPC{o_valid_q}};
  assign o_axis_tlast      = o_last_q;
  assign o_axis_tvalid     = o_valid_q;
  assign o_axis_ttimestamp = o_ts_q;
  assign o_axis_thas_time  = o_has_q;
  assign o_axis_teob       = o_eob_q;
  assign o_axis_teov       = 1'b0;
  assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_sounder_rx_sched.sv
// Directed bench for sounder_rx_sched: counting-data source, output capture, hand-computed expected beats.
`timescale 1ns/1ps
module tb_sounder_rx_sched;
  localparam int WIDTH = 32, NIPC = 2, CNT_W = 32, ANT_W = 8, SPP_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  arm = 1'b0;
  logic [NIPC*WIDTH-1:0] i_axis_tdata;
  logic                  i_axis_tlast = 1'b0;
  logic                  i_axis_tvalid;
  logic                  i_axis_tready;
  logic [63:0]           i_axis_ttimestamp = 64'd1000;
  logic                  i_axis_thas_time;
  logic [NIPC*WIDTH-1:0] o_axis_tdata;
  logic [NIPC-1:0]       o_axis_tkeep;
  logic                  o_axis_tlast, o_axis_tvalid;
  logic                  o_axis_tready = 1'b1;
  logic [63:0]           o_axis_ttimestamp;
  logic                  o_axis_thas_time, o_axis_teob, o_axis_teov;
  logic [CNT_W-1:0]      p = '0, r = '0, ml = '0;
  logic [ANT_W-1:0]      nant = '0;
  logic [15:0]           nsnap = '0;
  logic [SPP_W-1:0]      spp = '0;
  logic                  busy;

  sounder_rx_sched #(.WIDTH(WIDTH), .NIPC(NIPC), .CNT_W(CNT_W), .ANT_W(ANT_W), .SPP_W(SPP_W)) dut (
    .clk(clk), .rst(rst), .arm(arm),
    .i_axis_tdata(i_axis_tdata), .i_axis_tlast(i_axis_tlast), .i_axis_tvalid(i_axis_tvalid),
    .i_axis_tready(i_axis_tready), .i_axis_ttimestamp(i_axis_ttimestamp),
    .i_axis_thas_time(i_axis_thas_time),
    .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep), .o_axis_tlast(o_axis_tlast),
    .o_axis_tvalid(o_axis_tvalid), .o_axis_tready(o_axis_tready),
    .o_axis_ttimestamp(o_axis_ttimestamp), .o_axis_thas_time(o_axis_thas_time),
    .o_axis_teob(o_axis_teob), .o_axis_teov(o_axis_teov),
    .p(p), .r(r), .ml(ml), .nant(nant), .nsnap(nsnap), .spp(spp), .busy(busy)
  );

  typedef struct {
    logic [63:0] data;
    logic [63:0] ts;
    logic [1:0]  keep;
    logic        last, eob, has;
  } beat_t;

  beat_t got_q[$];
  int    checks = 0, failures = 0;
  int    src_n = 0;
  logic  src_valid = 1'b0, has_level = 1'b1, ready_level = 1'b1;
  bit    rand_mode = 1'b0, blk_chk = 1'b0;
  int    blk_bad = 0;

  assign i_axis_tdata     = {32'(src_n), 32'(src_n)};
  assign i_axis_tvalid    = src_valid;
  assign i_axis_thas_time = has_level;

  // Source: data index advances on each accepted beat and restarts at 0 across reset.
  initial begin : source
    bit f, rs;
    forever begin
      @(negedge clk);
      f  = i_axis_tvalid && i_axis_tready;
      rs = rst;
      @(posedge clk);
      #1;
      if (rs) src_n = 0;
      else if (f) src_n = src_n + 1;
    end
  end

  initial begin : sink
    forever begin
      @(posedge clk);
      #1;
      o_axis_tready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_level;
    end
  end

  // Forwarded input indices for the long backpressure run (p=2 ml=4 nant=2 r=3, 125 snapshots).
  function automatic bit is_fwd4(input int n);
    int m;
    if (n < 2 || n > 1623) return 1'b0;
    m = (n - 2) % 13;
    return (m < 4) || (m >= 6 && m < 10);
  endfunction

  always @(negedge clk) begin
    if (!rst && o_axis_tvalid && o_axis_tready)
      got_q.push_back('{data: o_axis_tdata, ts: o_axis_ttimestamp, keep: o_axis_tkeep,
                        last: o_axis_tlast, eob: o_axis_teob, has: o_axis_thas_time});
    if (blk_chk && !rst && o_axis_tvalid && !o_axis_tready && i_axis_tvalid && i_axis_tready
        && is_fwd4(src_n))
      blk_bad <= blk_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; src_valid = 1'b0; rand_mode = 1'b0; ready_level = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_cfg(input int pp, input int rr, input int mm, input int na,
                         input int ns, input int sp);
    p = CNT_W'(pp); r = CNT_W'(rr); ml = CNT_W'(mm);
    nant = ANT_W'(na); nsnap = 16'(ns); spp = SPP_W'(sp);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_beats(input string tag, input int base, input int n, input int budget);
    int c = 0;
    while (got_q.size() < base + n && c < budget) begin
      tick();
      c++;
    end
    checks++;
    assert (got_q.size() >= base + n) else begin
      failures++;
      $error("FAIL %s_timeout: got %0d beats, expected %0d", tag, got_q.size() - base, n);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input int n, input bit last,
                          input bit eob, input longint unsigned ts, input bit has);
    logic [63:0] exp_d;
    exp_d = {32'(n), 32'(n)};
    checks++;
    if (idx >= got_q.size()) begin
      failures++;
      $display("FAIL %s beat%0d: got no beat, expected data %0d", tag, idx, n);
    end else begin
      assert (got_q[idx].data === exp_d && got_q[idx].last === last && got_q[idx].eob === eob &&
              got_q[idx].ts === ts && got_q[idx].has === has && got_q[idx].keep === 2'b11)
      else begin
        failures++;
        $error("FAIL %s beat%0d: got data=%0d last=%b eob=%b ts=%0d has=%b keep=%b, expected data=%0d last=%b eob=%b ts=%0d has=%b keep=11",
               tag, idx, got_q[idx].data[31:0], got_q[idx].last, got_q[idx].eob, got_q[idx].ts,
               got_q[idx].has, got_q[idx].keep, n, last, eob, ts, has);
      end
    end
  endtask

  initial begin : main
    int base;
    int s, w, a, j, n, n0;

    do_reset();
    chk("rst_tvalid", 64'(o_axis_tvalid), 64'd0);
    chk("rst_tkeep", 64'(o_axis_tkeep), 64'd0);
    chk("rst_tlast", 64'(o_axis_tlast), 64'd0);
    chk("rst_teob", 64'(o_axis_teob), 64'd0);
    chk("rst_teov", 64'(o_axis_teov), 64'd0);
    chk("rst_thas", 64'(o_axis_thas_time), 64'd0);
    chk("rst_ts", o_axis_ttimestamp, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_iready", 64'(i_axis_tready), 64'd1);

    // 1: two antennas, one snapshot; arm rises together with the first input beat.
    do_reset();
    set_cfg(2, 3, 4, 2, 1, 4);
    has_level = 1'b1;
    base = got_q.size();
    arm = 1'b1; src_valid = 1'b1;
    wait_beats("t1", base, 8, 200);
    repeat (20) tick();
    chk("t1_count", 64'(got_q.size() - base), 64'd8);
    chk("t1_busy", 64'(busy), 64'd0);
    chk_beat("t1", base + 0, 2, 0, 0, 1004, 1);
    chk_beat("t1", base + 1, 3, 0, 0, 1004, 1);
    chk_beat("t1", base + 2, 4, 0, 0, 1004, 1);
    chk_beat("t1", base + 3, 5, 1, 0, 1004, 1);
    chk_beat("t1", base + 4, 8, 0, 0, 1016, 1);
    chk_beat("t1", base + 5, 9, 0, 0, 1016, 1);
    chk_beat("t1", base + 6, 10, 0, 0, 1016, 1);
    chk_beat("t1", base + 7, 11, 1, 1, 1016, 1);

    // 2: no guard/repeat skip, short final packet, two snapshots, no time flag.
    do_reset();
    set_cfg(0, 0, 5, 1, 2, 2);
    has_level = 1'b0;
    base = got_q.size();
    arm = 1'b1;
    tick();
    src_valid = 1'b1;
    wait_beats("t2", base, 10, 200);
    repeat (20) tick();
    chk("t2_count", 64'(got_q.size() - base), 64'd10);
    chk("t2_busy", 64'(busy), 64'd0);
    chk_beat("t2", base + 0, 0, 0, 0, 1000, 0);
    chk_beat("t2", base + 1, 1, 1, 0, 1000, 0);
    chk_beat("t2", base + 2, 2, 0, 0, 1004, 0);
    chk_beat("t2", base + 3, 3, 1, 0, 1004, 0);
    chk_beat("t2", base + 4, 4, 1, 1, 1008, 0);
    chk_beat("t2", base + 5, 5, 0, 0, 1010, 0);
    chk_beat("t2", base + 6, 6, 1, 0, 1010, 0);
    chk_beat("t2", base + 7, 7, 0, 0, 1014, 0);
    chk_beat("t2", base + 8, 8, 1, 0, 1014, 0);
    chk_beat("t2", base + 9, 9, 1, 1, 1018, 0);

    // 3: timestamp of each output packet start.
    do_reset();
    set_cfg(3, 0, 4, 1, 1, 2);
    has_level = 1'b1;
    base = got_q.size();
    arm = 1'b1; src_valid = 1'b1;
    wait_beats("t3", base, 4, 200);
    repeat (10) tick();
    chk("t3_count", 64'(got_q.size() - base), 64'd4);
    chk_beat("t3", base + 0, 3, 0, 0, 1006, 1);
    chk_beat("t3", base + 1, 4, 1, 0, 1006, 1);
    chk_beat("t3", base + 2, 5, 0, 0, 1010, 1);
    chk_beat("t3", base + 3, 6, 1, 1, 1010, 1);

    // 4: 1000 output beats under 30% random output ready.
    do_reset();
    set_cfg(2, 3, 4, 2, 125, 3);
    base = got_q.size();
    blk_chk = 1'b1; rand_mode = 1'b1;
    arm = 1'b1; src_valid = 1'b1;
    wait_beats("t4", base, 1000, 30000);
    repeat (20) tick();
    blk_chk = 1'b0; rand_mode = 1'b0;
    chk("t4_count", 64'(got_q.size() - base), 64'd1000);
    chk("t4_blocked_accept", 64'(blk_bad), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 1000; k++) begin
      s = k / 8; w = k % 8; a = w / 4; j = w % 4;
      n = 2 + 13 * s + 6 * a + j;
      n0 = (j == 3) ? n : n - j;
      chk_beat("t4", base + k, n, (j >= 2), (a == 1 && j == 3), 64'(1000 + 2 * n0), 1);
    end

    // 5: arm dropped after 3 of 8 window beats; window completes, then idle.
    do_reset();
    set_cfg(1, 1, 8, 1, 0, 8);
    base = got_q.size();
    arm = 1'b1; src_valid = 1'b1;
    for (int c = 0; c < 100 && src_n < 4; c++) begin
      @(posedge clk);
      #2;
    end
    arm = 1'b0;
    wait_beats("t5", base, 8, 100);
    repeat (40) tick();
    chk("t5_count", 64'(got_q.size() - base), 64'd8);
    chk("t5_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 8; k++)
      chk_beat("t5", base + k, k + 1, (k == 7), (k == 7), 1002, 1);

    // 6: reset while an output beat is held, then re-arm.
    do_reset();
    set_cfg(2, 3, 4, 2, 0, 4);
    ready_level = 1'b0;
    tick();
    arm = 1'b1; src_valid = 1'b1;
    repeat (10) tick();
    chk("t6_held_valid", 64'(o_axis_tvalid), 64'd1);
    rst = 1'b1; arm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_tvalid", 64'(o_axis_tvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_iready", 64'(i_axis_tready), 64'd1);
    tick();
    rst = 1'b0; ready_level = 1'b1;
    base = got_q.size();
    arm = 1'b1;
    wait_beats("t6", base, 4, 200);
    chk_beat("t6", base + 0, 2, 0, 0, 1004, 1);
    chk_beat("t6", base + 1, 3, 0, 0, 1004, 1);
    chk_beat("t6", base + 2, 4, 0, 0, 1004, 1);
    chk_beat("t6", base + 3, 5, 1, 0, 1004, 1);
    arm = 1'b0; src_valid = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
